// File: rtl/dft_fifo_lvl_pkg.sv
// Shared width defaults and helpers for the DFT sample FIFO.
// Imported by the interface, the RAM and the FIFO top level.
package dft_fifo_lvl_pkg;

  localparam int DFT_DATA_W = 12;
  localparam int DFT_ADDR_W = 8;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/dft_fifo_lvl_if.sv
// Write/read/status bundle of the DFT sample FIFO.
// The master side is the datapath user; the slave side is the FIFO.
interface dft_fifo_lvl_if
  import dft_fifo_lvl_pkg::*;
#(
  parameter int DATA_W = DFT_DATA_W,
  parameter int ADDR_W = DFT_ADDR_W
);

  logic [DATA_W-1:0] wdata;
  logic              wr;
  logic              full;
  logic              almost_full;
  logic              rd;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   level;
  logic              clr_err;
  logic              ovf;
  logic              udf;

  modport master (
    output wdata, wr, rd, clr_err,
    input  full, almost_full, rdata, rvalid, empty, almost_empty, level, ovf, udf
  );

  modport slave (
    input  wdata, wr, rd, clr_err,
    output full, almost_full, rdata, rvalid, empty, almost_empty, level, ovf, udf
  );

endinterface

// File: rtl/dft_fifo_lvl_ram.sv
// Simple dual-port storage for the DFT FIFO: synchronous write, registered read.
// Only the read register is reset; the array itself is not.
module dft_fifo_lvl_ram
  import dft_fifo_lvl_pkg::*;
#(
  parameter int ADDR_W = DFT_ADDR_W,
  parameter int DATA_W = DFT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dft_fifo_lvl.sv
// DFT sample FIFO with fill level, almost-full/empty thresholds and sticky error flags.
// Define DFT_FIFO_FWFT_EN for show-ahead reads; default build is standard (pop then data).
module dft_fifo_lvl
  import dft_fifo_lvl_pkg::*;
#(
  parameter int ADDR_W = DFT_ADDR_W,
  parameter int DATA_W = DFT_DATA_W,
  parameter int AF_THR = 2**ADDR_W - 4,
  parameter int AE_THR = 4
) (
  input logic           clk,
  input logic           rst_n,
  dft_fifo_lvl_if.slave bus
);

  localparam int              LW   = ADDR_W + 1;
  localparam logic [ADDR_W:0] AF_L = LW'(AF_THR);
  localparam logic [ADDR_W:0] AE_L = LW'(AE_THR);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  // empty_q tracks RAM words old enough to read; in show-ahead mode it feeds the prefetch
  logic              empty_q, empty_d, full_q, full_d;
  logic              af_q, af_d, ae_q, ae_d, ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_acc, pop, ram_re, out_empty;
  logic [DATA_W-1:0] ram_rdata;

  assign wr_acc = bus.wr & ~full_q;

`ifdef DFT_FIFO_FWFT_EN
  localparam logic [ADDR_W:0] DEPTH_L = LW'(2**ADDR_W);
  logic out_vld_q, out_vld_d;

  assign out_empty = ~out_vld_q;
  assign pop       = bus.rd & out_vld_q;
  assign ram_re    = ~empty_q & (~out_vld_q | pop);
  assign out_vld_d = ram_re | (out_vld_q & ~pop);
`else
  logic rvalid_q;

  assign out_empty = empty_q;
  assign pop       = bus.rd & ~empty_q;
  assign ram_re    = pop;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + LW'(wr_acc);
    rd_ptr_d = rd_ptr_q + LW'(ram_re);
    level_d  = level_q + LW'(wr_acc) - LW'(pop);
    // old write pointer: a word becomes readable one edge after it is written
    empty_d  = (wr_ptr_q == rd_ptr_d);
`ifdef DFT_FIFO_FWFT_EN
    full_d   = (level_d == DEPTH_L);
`else
    full_d   = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
               (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
`endif
    af_d     = (level_d >= AF_L);
    ae_d     = (level_d <= AE_L);
    ovf_d    = (bus.wr & full_q) | (ovf_q & ~bus.clr_err);
    udf_d    = (bus.rd & out_empty) | (udf_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
`ifdef DFT_FIFO_FWFT_EN
      out_vld_q <= 1'b0;
`else
      rvalid_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
`ifdef DFT_FIFO_FWFT_EN
      out_vld_q <= out_vld_d;
`else
      rvalid_q  <= pop;
`endif
    end
  end

  dft_fifo_lvl_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (bus.wdata),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.empty        = out_empty;
  assign bus.almost_empty = ae_q;
  assign bus.level        = level_q;
  assign bus.ovf          = ovf_q;
  assign bus.udf          = udf_q;
  assign bus.rdata        = ram_rdata;
`ifdef DFT_FIFO_FWFT_EN
  assign bus.rvalid       = out_vld_q;
`else
  assign bus.rvalid       = rvalid_q;
`endif

endmodule
